// File: rtl/sram_chunk_writer.sv
// Sparse-encodes dense beats and issues chunk-addressed SRAM writes for one command of N chunks.
// Latency: an accepted beat appears on the wr_* outputs one cycle later; done_o coincides with the final write.
// Backpressure: in_ready_o is high only while running; input stalls freeze all counters. Optional SPARSITY_STAT_EN adds nz_count_o.
module sram_chunk_writer #(
  parameter int BUS_SIZE       = 64,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int SRAM_NUM       = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [$clog2(SRAM_NUM)-1:0]         chunk_base_i,
  input  logic [$clog2(SRAM_NUM):0]           chunk_num_i,
  output logic                                busy_o,
  output logic                                done_o,
`ifdef SPARSITY_STAT_EN
  output logic [$clog2(SRAM_NUM*WR_DAT_CYC_NUM*BUS_SIZE+1)-1:0] nz_count_o,
`endif
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [BUS_SIZE*8-1:0]               in_data_i,
  output logic [BUS_SIZE-1:0]                 wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]               wr_nonzero_data_o,
  output logic                                wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   wr_dat_count_o,
  output logic [$clog2(SRAM_NUM)-1:0]         wr_chunk_count_o
);

  localparam int CW = $clog2(SRAM_NUM);
  localparam int DW = $clog2(WR_DAT_CYC_NUM);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       dat_cnt;
  logic [CW-1:0]       chunk_cnt;
  logic [CW:0]         chunks_left;
  logic                accept, start_take, chunk_end, last;
  logic [BUS_SIZE-1:0]   enc_map;
  logic [BUS_SIZE*8-1:0] enc_data;
  int                  n;

  // Handshake and command qualifiers are derived from the registered state only.
  assign accept     = in_valid_i && (state == RUN);
  assign start_take = start_i && (state == IDLE);
  assign chunk_end  = (dat_cnt == DW'(WR_DAT_CYC_NUM - 1));
  assign last       = chunk_end && (chunks_left == (CW+1)'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; a zero-chunk command goes straight to DONE.
  always_comb begin
    state_nxt  = state;
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = (chunk_num_i == '0) ? DONE : RUN;
      RUN: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Compaction: each nonzero byte lands at the next free output slot in ascending byte order.
  always_comb begin
    enc_map  = '0;
    enc_data = '0;
    n        = 0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (in_data_i[8*k +: 8] != 8'h00) begin
        enc_map[k]          = 1'b1;
        enc_data[8*n +: 8]  = in_data_i[8*k +: 8];
        n                   = n + 1;
      end
    end
  end

  // Beat/chunk counters and the registered write port; wr_* data holds between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_cnt           <= '0;
      chunk_cnt         <= '0;
      chunks_left       <= '0;
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_dat_count_o    <= '0;
      wr_chunk_count_o  <= '0;
    end else begin
      wr_valid_o <= accept;
      if (start_take) begin
        dat_cnt     <= '0;
        chunk_cnt   <= chunk_base_i;
        chunks_left <= chunk_num_i;
      end
      if (accept) begin
        wr_sparsemap_o    <= enc_map;
        wr_nonzero_data_o <= enc_data;
        wr_dat_count_o    <= dat_cnt;
        wr_chunk_count_o  <= chunk_cnt;
        if (chunk_end) begin
          dat_cnt     <= '0;
          chunks_left <= chunks_left - 1'b1;
          chunk_cnt   <= (chunk_cnt == CW'(SRAM_NUM - 1)) ? '0 : chunk_cnt + 1'b1;
        end else begin
          dat_cnt <= dat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPARSITY_STAT_EN
  localparam int PW = $clog2(BUS_SIZE + 1);
  localparam int SW = $clog2(SRAM_NUM*WR_DAT_CYC_NUM*BUS_SIZE + 1);
  logic [PW-1:0] enc_pop;
  assign enc_pop = PW'(n);

  // Nonzero-byte tally for the current command; updated with each write so it is final at done_o.
  always_ff @(posedge clk_i) begin
    if (rst_i)           nz_count_o <= '0;
    else if (start_take) nz_count_o <= '0;
    else if (accept)     nz_count_o <= nz_count_o + SW'(enc_pop);
  end
`endif

endmodule
